fetch_ctrl: RTL and testbench

Sequencing controller for the instruction/data fetch path. Accepts one fetch request at a time and resolves it in one of two ways. On a cache hit it returns cache data one cycle later. On a miss it runs a bounded req/ack handshake to the memory side, with timeout and retry, then returns the memory data. It is the block whose handshakes the fetch-path assertions (`req |-> ##[1:5] ack`, `cache_hit |=> data_ready`) are written against.

---
 rtl/fetch_ctrl_pkg.sv | 23 ++
 rtl/fetch_ctrl_ack_timer.sv | 32 +++
 rtl/fetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and default parameters for the fetch sequencing controller.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HIT  = 3'd1,
        REQ  = 3'd2,
        GAP  = 3'd3,
        RESP = 3'd4,
        ERR  = 3'd5
    } fetch_state_e;

    localparam int unsigned DefDataW      = 32;
    localparam int unsigned DefAddrW      = 16;
    localparam int unsigned DefAckTimeout = 5;
    localparam int unsigned DefMaxRetry   = 2;

    // $clog2 that never returns 0, so a counter always has at least one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/fetch_ctrl_ack_timer.sv
// Per-attempt ack wait timer: loaded on entry to REQ, counts down one per REQ cycle.
module ack_timer
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = DefAckTimeout
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = clog2_min1(ACK_TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= CntW'(ACK_TIMEOUT);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // High during the last permitted REQ cycle of the current attempt.
    assign expired_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one request at a time, cache-hit fast path or memory req/ack with retry.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned ACK_TIMEOUT = DefAckTimeout,
    parameter int unsigned MAX_RETRY   = DefMaxRetry
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              cache_hit,
    input  logic [DATA_W-1:0] cache_data,
    output logic              req,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              data_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              error
);

    localparam int unsigned RetryW = clog2_min1(MAX_RETRY + 1);

    fetch_state_e      state_q;
    logic [RetryW-1:0] retry_q;
    logic              req_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic              busy_q;
    logic              data_ready_q;
    logic [DATA_W-1:0] data_out_q;
    logic              done_q;
    logic              error_q;

    logic tmr_clr;
    logic tmr_load;
    logic tmr_en;
    logic tmr_expired;

    ack_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_ack_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (tmr_clr),
        .load_i   (tmr_load),
        .en_i     (tmr_en),
        .expired_o(tmr_expired)
    );

    always_comb begin
        tmr_clr  = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch) begin
                    tmr_clr  = cache_hit;
                    tmr_load = !cache_hit;
                end
            end
            REQ: begin
                tmr_en  = 1'b1;
                tmr_clr = ack || tmr_expired;
            end
            GAP:     tmr_load = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            retry_q      <= '0;
            req_q        <= 1'b0;
            req_addr_q   <= '0;
            busy_q       <= 1'b0;
            data_ready_q <= 1'b0;
            data_out_q   <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            data_ready_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fetch) begin
                        busy_q     <= 1'b1;
                        req_addr_q <= fetch_addr;
                        retry_q    <= '0;
                        if (cache_hit) begin
                            data_out_q   <= cache_data;
                            data_ready_q <= 1'b1;
                            done_q       <= 1'b1;
                            state_q      <= HIT;
                        end else begin
                            req_q   <= 1'b1;
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    // An ack in the final wait cycle still wins over the timeout.
                    if (ack) begin
                        req_q        <= 1'b0;
                        data_out_q   <= mem_data;
                        data_ready_q <= 1'b1;
                        done_q       <= 1'b1;
                        state_q      <= RESP;
                    end else if (tmr_expired) begin
                        req_q <= 1'b0;
                        if (retry_q < RetryW'(MAX_RETRY)) begin
                            state_q <= GAP;
                        end else begin
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                            state_q <= ERR;
                        end
                    end
                end
                GAP: begin
                    retry_q <= retry_q + 1'b1;
                    req_q   <= 1'b1;
                    state_q <= REQ;
                end
                HIT, RESP, ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req        = req_q;
    assign req_addr   = req_addr_q;
    assign busy       = busy_q;
    assign data_ready = data_ready_q;
    assign data_out   = data_out_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: transaction table plus completion scoreboard.
module tb_fetch_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;
    localparam int         TO = 5;
    localparam int         MR = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch;
    logic [AW-1:0] fetch_addr;
    logic          cache_hit;
    logic [DW-1:0] cache_data;
    logic          req;
    logic [AW-1:0] req_addr;
    logic          ack;
    logic [DW-1:0] mem_data;
    logic          busy;
    logic          data_ready;
    logic [DW-1:0] data_out;
    logic          done;
    logic          error;

    fetch_ctrl #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .ACK_TIMEOUT(TO),
        .MAX_RETRY  (MR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch     (fetch),
        .fetch_addr(fetch_addr),
        .cache_hit (cache_hit),
        .cache_data(cache_data),
        .req       (req),
        .req_addr  (req_addr),
        .ack       (ack),
        .mem_data  (mem_data),
        .busy      (busy),
        .data_ready(data_ready),
        .data_out  (data_out),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] last_data = '0;

    // Completion monitor: every done/data_ready/error pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done || data_ready || error) begin
            if (sb.size() == 0) begin
                chk("unexpected_completion", {61'd0, done, data_ready, error}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("done", done, 1'b1);
                chk("data_ready", data_ready, !mon_e.err);
                chk("error", error, mon_e.err);
                chk("data_out", data_out, mon_e.data);
            end
        end
    end

    typedef struct {
        bit          is_hit;
        logic [15:0] addr;
        logic [31:0] data;
        int          ack_rel;     // cycle offset from acceptance where ack is given, 0 = never
        bit          gap_ack;     // also raise ack during GAP cycles
        bit          busy_fetch;  // keep issuing fetches while busy
        int          exp_lat;     // cycles from acceptance to done
        bit          exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        fetch      = 1'b0;
        cache_hit  = 1'b1;
        cache_data = $urandom;
        ack        = 1'b1;
        mem_data   = $urandom;
        step();
        chk("idle_busy", busy, 1'b0);
        chk("idle_req", req, 1'b0);
        ack       = 1'b0;
        cache_hit = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        exp_t e;
        bit   req_exp;
        e.cyc  = cyc + v.exp_lat;
        e.err  = v.exp_err;
        e.data = v.exp_err ? last_data : v.data;
        if (!v.exp_err) last_data = v.data;
        sb.push_back(e);

        fetch      = 1'b1;
        fetch_addr = v.addr;
        cache_hit  = v.is_hit;
        cache_data = v.is_hit ? v.data : $urandom;
        ack        = v.is_hit;
        mem_data   = $urandom;
        step();
        for (int rel = 1; rel < v.exp_lat; rel++) begin
            // REQ occupies positions 1..TO of each TO+1-cycle attempt, GAP the last.
            req_exp = (((rel - 1) % (TO + 1)) + 1) <= TO;
            chk("req", req, req_exp);
            chk("busy", busy, 1'b1);
            if (req_exp) chk("req_addr", req_addr, v.addr);
            ack        = (rel == v.ack_rel) || (v.gap_ack && !req_exp);
            mem_data   = (rel == v.ack_rel) ? v.data : $urandom;
            fetch      = v.busy_fetch;
            fetch_addr = 16'($urandom);
            cache_hit  = 1'($urandom_range(0, 1));
            cache_data = $urandom;
            step();
        end
        chk("req_at_done", req, 1'b0);
        chk("busy_at_done", busy, 1'b1);
        fetch     = v.busy_fetch;
        cache_hit = 1'b1;
        ack       = 1'b1;
        step();
        chk("busy_after_done", busy, 1'b0);
        chk("req_after_done", req, 1'b0);
        fetch     = 1'b0;
        cache_hit = 1'b0;
        ack       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0] = '{1'b1, 16'h0010, 32'hA5A5_0001, 0,  1'b0, 1'b1, 1,  1'b0};
        vecs[1] = '{1'b0, 16'h0040, 32'h1234_5678, 3,  1'b0, 1'b0, 4,  1'b0};
        vecs[2] = '{1'b0, 16'h0100, 32'hCAFE_0005, 5,  1'b0, 1'b0, 6,  1'b0};
        vecs[3] = '{1'b0, 16'h0200, 32'hD00D_0008, 8,  1'b1, 1'b0, 9,  1'b0};
        vecs[4] = '{1'b0, 16'h0300, 32'h0BAD_F00D, 17, 1'b0, 1'b0, 18, 1'b0};
        vecs[5] = '{1'b0, 16'h0400, 32'hDEAD_DEAD, 0,  1'b1, 1'b1, 18, 1'b1};
        vecs[6] = '{1'b1, 16'hFFFF, 32'h0000_BEEF, 0,  1'b0, 1'b0, 1,  1'b0};
        vecs[7] = '{1'b0, 16'h8001, 32'h7777_0001, 1,  1'b0, 1'b1, 2,  1'b0};

        rst        = 1'b1;
        fetch      = 1'b0;
        fetch_addr = '0;
        cache_hit  = 1'b0;
        cache_data = '0;
        ack        = 1'b0;
        mem_data   = '0;
        repeat (3) step();
        chk("rst_req", req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data_ready", data_ready, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_data_out", data_out, 32'd0);
        chk("rst_req_addr", req_addr, 16'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            idle_cycle();
            run_txn(vecs[i]);
        end

        // Reset while a miss is waiting for ack.
        idle_cycle();
        fetch      = 1'b1;
        fetch_addr = 16'h0500;
        cache_hit  = 1'b0;
        step();
        chk("rmid_req_t1", req, 1'b1);
        fetch = 1'b0;
        step();
        step();
        chk("rmid_req_t3", req, 1'b1);
        rst = 1'b1;
        step();
        chk("rmid_req", req, 1'b0);
        chk("rmid_busy", busy, 1'b0);
        chk("rmid_done", done, 1'b0);
        chk("rmid_data_ready", data_ready, 1'b0);
        chk("rmid_error", error, 1'b0);
        chk("rmid_data_out", data_out, 32'd0);
        chk("rmid_req_addr", req_addr, 16'd0);
        rst       = 1'b0;
        last_data = '0;
        ack       = 1'b1;
        mem_data  = 32'h5555_AAAA;
        step();
        step();
        chk("post_rst_req", req, 1'b0);
        chk("post_rst_busy", busy, 1'b0);
        ack = 1'b0;
        v = '{1'b0, 16'h0600, 32'h600D_0002, 2, 1'b0, 1'b0, 3, 1'b0};
        run_txn(v);

        repeat (2) step();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
